vc_latency_credit_fifo: RTL and testbench
=========================================

Name: vc_latency_credit_fifo

Overview:
Output-side queue that sits directly downstream of a fixed-latency delay line (vc_cycle_buffer carrying a valid bit alongside data). It captures every result the delay line emits and presents it on a val/rdy dequeue interface. It also runs a credit counter that gates upstream issue, so a stalled consumer can never cause a result to be dropped. Results leave in arrival order.

Parameters:
DATA_WIDTH, 12, width of result data.
NUM_CYCLES, 1, latency of the upstream delay line; used only for the DEPTH legality check and throughput sizing.
DEPTH, 4, number of queue entries; must be >= 1; sustained 1/cycle throughput requires DEPTH >= NUM_CYCLES+2.

Ports:
clk  input  1  sole clock, rising edge.
reset  input  1  asynchronous, active-high reset.
issue_val  input  1  upstream wants to launch an op into the delay line this cycle.
issue_rdy  output  1  credit available; an issue fires when issue_val && issue_rdy.
pipe_val  input  1  delay-line output valid (arrives NUM_CYCLES after the issue).
pipe_data  input  DATA_WIDTH  delay-line output data.
deq_val  output  1  queue head valid.
deq_rdy  input  1  consumer accepts head.
deq_data  output  DATA_WIDTH  queue head data.
count  output  $clog2(DEPTH+1)  current queue occupancy.
credits  output  $clog2(DEPTH+1)  free credits.
overflow  output  1  sticky error flag.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - credits=DEPTH, count=0, head/tail pointers=0, overflow=0.
  - issue_rdy=1, deq_val=0. deq_data is don't-care while deq_val=0.
  - Reset mid-operation discards all queued and in-flight results. The upstream delay line is reset by the same signal.
- issue_rdy = (credits != 0). Purely combinational from the register, with no dependence on issue_val.
- Credit counter update per cycle:
  - issue fire only: credits-1.
  - deq fire only (deq_val && deq_rdy): credits+1.
  - Both or neither: unchanged.
  - Invariant: credits + count + in-flight = DEPTH.
- Enqueue: pipe_val=1 writes pipe_data at tail at the clock edge and advances tail, wrapping DEPTH-1 -> 0. DEPTH need not be a power of two.
- Dequeue: deq_val = (count != 0). deq_data = entry at head, driven from storage. On deq fire, head advances with the same wrap rule.
- No bypass: a value enqueued in cycle t is visible on deq_val/deq_data at cycle t+1 at the earliest. Minimum issue->deq_val latency is NUM_CYCLES+1.
- Occupancy: count+1 on enqueue only, count-1 on deq fire only, unchanged when both or neither.
- Full with simultaneous dequeue (count=DEPTH, pipe_val, deq fire): legal. The write reuses the freed slot, count stays DEPTH, overflow is not set.
- Overflow (pipe_val while count=DEPTH and no deq fire):
  - Data is dropped; count and pointers are unchanged.
  - overflow sets to 1 and holds until reset.
  - Cannot occur when upstream obeys issue_rdy; it flags a protocol violation.
- Empty with deq_rdy=1: no effect.
- deq_data must stay stable while deq_val=1 and deq_rdy=0.
- Elaboration check: DEPTH < 1 is a fatal error. DEPTH < NUM_CYCLES+2 produces a warning only (correct but throughput-limited).

Test Plan:
1. DEPTH=4, NUM_CYCLES=2, deq_rdy=1, issue_val held 1 with data 0x001,0x002,...:
   -> issue_rdy stays 1; deq fires every cycle from cycle 3; outputs 0x001,0x002,... in order; count never exceeds 1.
2. Same config, deq_rdy=0, issue_val=1:
   -> exactly 4 issues fire (cycles 0-3); issue_rdy=0 from cycle 4; count reaches 4 at cycle 6; overflow stays 0. Then deq_rdy=1 -> 0x001..0x004 drain one per cycle; issue_rdy returns 1 the cycle after the first deq fire.
3. Full (count=4), pipe_val=1 forced with data 0xABC together with deq fire:
   -> count stays 4, overflow=0, 0xABC emerges last. Repeat with deq_rdy=0 -> overflow=1, 0xABC never appears, count=4.
4. DEPTH=3 (non-power-of-two), 10 items through with deq_rdy toggling 1,0,1,0:
   -> order preserved across pointer wrap; credits+count+in-flight=3 every cycle.
5. Reset asserted mid-stream with count=2 and 1 in flight, asynchronously between edges:
   -> immediately credits=DEPTH, count=0, deq_val=0, overflow=0; no stale data is dequeued after release.
6. deq_val=1, deq_rdy=0 held 5 cycles while pipe_val delivers 2 more items:
   -> deq_data unchanged for all 5 cycles; count increments by 2.

Source files
------------

// File: rtl/vc_latency_credit_fifo_if.sv
// ============================================================================
// vc_latency_credit_fifo_if
// ----------------------------------------------------------------------------
// Bundles the signals between the output-side credit FIFO and its
// environment: the upstream issue handshake, the delay-line output, the
// val/rdy dequeue port and the status outputs.
//
// Signals:
//   issue_val / issue_rdy : upstream launch request / credit available
//   pipe_val  / pipe_data : delay-line output (valid + result data)
//   deq_val / deq_rdy / deq_data : dequeue handshake and head data
//   count    : queue occupancy
//   credits  : free credits
//   overflow : sticky protocol-violation flag
//
// Modports:
//   master : environment side (drives issue/pipe/deq_rdy, observes the rest)
//   slave  : FIFO side
// ============================================================================
interface vc_latency_credit_fifo_if #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  issue_val;
    logic                  issue_rdy;
    logic                  pipe_val;
    logic [DATA_WIDTH-1:0] pipe_data;
    logic                  deq_val;
    logic                  deq_rdy;
    logic [DATA_WIDTH-1:0] deq_data;
    logic [CW-1:0]         count;
    logic [CW-1:0]         credits;
    logic                  overflow;

    modport master (
        output issue_val, pipe_val, pipe_data, deq_rdy,
        input  issue_rdy, deq_val, deq_data, count, credits, overflow
    );

    modport slave (
        input  issue_val, pipe_val, pipe_data, deq_rdy,
        output issue_rdy, deq_val, deq_data, count, credits, overflow
    );
endinterface

// File: rtl/vc_latency_credit_fifo.sv
// ============================================================================
// vc_latency_credit_fifo
// ----------------------------------------------------------------------------
// Output-side queue placed directly after a fixed-latency delay line. Every
// result the delay line emits is captured and presented, in arrival order, on
// a val/rdy dequeue port. A credit counter gates upstream issue so that a
// stalled consumer can never cause a result to be lost: an issue consumes a
// credit, a dequeue returns one, so credits + count + in-flight = DEPTH.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset (also resets the delay line)
//   bus   : slave side of vc_latency_credit_fifo_if (issue, pipe, deq, status)
//
// Parameters:
//   DATA_WIDTH : result width
//   NUM_CYCLES : upstream delay-line latency (only used for the depth check)
//   DEPTH      : number of entries, any value >= 1 (need not be a power of 2)
// ============================================================================
module vc_latency_credit_fifo #(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_CYCLES = 1,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    vc_latency_credit_fifo_if.slave    bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    // Elaboration-time legality: too shallow a queue still works correctly
    // but cannot sustain one result per cycle.
    generate
        if (DEPTH < 1) begin : g_bad_depth
            $fatal(1, "vc_latency_credit_fifo: DEPTH must be >= 1");
        end else if (DEPTH < NUM_CYCLES + 2) begin : g_slow_depth
            $warning("vc_latency_credit_fifo: DEPTH < NUM_CYCLES+2 limits throughput");
        end
    endgenerate

    logic [CW-1:0]         credits_q, credits_d;
    logic [CW-1:0]         count_q,   count_d;
    logic [PW-1:0]         head_q,    head_d;
    logic [PW-1:0]         tail_q,    tail_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic issue_fire;
    logic deq_fire;
    logic enq_ok;

    // Next-state logic. A write into a full queue is only legal when the head
    // leaves in the same cycle; the write then lands in the slot being freed.
    // Otherwise the data is dropped and the sticky overflow flag records the
    // upstream protocol violation.
    always_comb begin
        issue_fire = bus.issue_val && (credits_q != '0);
        deq_fire   = bus.deq_rdy && (count_q != '0);
        enq_ok     = bus.pipe_val && ((count_q != DEPTH_C) || deq_fire);

        credits_d = credits_q;
        if (issue_fire && !deq_fire) begin
            credits_d = credits_q - CW'(1);
        end else if (deq_fire && !issue_fire) begin
            credits_d = credits_q + CW'(1);
        end

        count_d = count_q;
        if (enq_ok && !deq_fire) begin
            count_d = count_q + CW'(1);
        end else if (deq_fire && !enq_ok) begin
            count_d = count_q - CW'(1);
        end

        head_d = head_q;
        if (deq_fire) begin
            head_d = (head_q == LAST_C) ? '0 : head_q + PW'(1);
        end

        tail_d = tail_q;
        if (enq_ok) begin
            tail_d = (tail_q == LAST_C) ? '0 : tail_q + PW'(1);
        end

        overflow_d = overflow_q
                   | (bus.pipe_val && (count_q == DEPTH_C) && !deq_fire);

        mem_d = mem_q;
        if (enq_ok) begin
            mem_d[tail_q] = bus.pipe_data;
        end
    end

    // Control state; reset drops everything queued and returns all credits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits_q  <= DEPTH_C;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage needs no reset: it is only observed while count != 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Outputs come straight from registers; there is no enqueue bypass, so a
    // result is visible the cycle after it is written.
    assign bus.issue_rdy = (credits_q != '0);
    assign bus.deq_val   = (count_q != '0);
    assign bus.deq_data  = mem_q[head_q];
    assign bus.count     = count_q;
    assign bus.credits   = credits_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_vc_latency_credit_fifo.sv
// ============================================================================
// tb_vc_latency_credit_fifo
// ----------------------------------------------------------------------------
// Drives the FIFO from a behavioural upstream (a queue standing in for the
// delay line) and compares it against a queue-based reference. Results that
// the reference accepts go into a scoreboard; a separate monitor pops the
// scoreboard on every dequeue the DUT performs.
// ============================================================================
module tb_vc_latency_credit_fifo;

    localparam int DW    = 12;
    localparam int NC    = 1;
    localparam int DEPTH = 3;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } slot_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    vc_latency_credit_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    vc_latency_credit_fifo #(
        .DATA_WIDTH (DW),
        .NUM_CYCLES (NC),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb_q [$];
    slot_t         dl [$];
    int            exp_count     = 0;
    bit            m_ovf         = 1'b0;
    bit            check_credits = 1'b1;
    logic [DW-1:0] next_data     = 12'h001;
    logic [DW-1:0] mon_exp;

    // Number of results still travelling through the modelled delay line.
    function automatic int inflight();
        int n = 0;
        foreach (dl[i]) if (dl[i].v) n++;
        return n;
    endfunction

    // Free credits follow from the conservation rule.
    function automatic int model_credits();
        return DEPTH - exp_count - inflight();
    endfunction

    task automatic compare(input string name, input logic [31:0] actual,
                           input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reset_model();
        sb_q.delete();
        dl.delete();
        for (int i = 0; i < NC; i++) dl.push_back('0);
        exp_count     = 0;
        m_ovf         = 1'b0;
        check_credits = 1'b1;
    endtask

    // Compares every status output, and the head data, against the reference.
    task automatic check_output();
        if (check_credits) begin
            compare("issue_rdy", 32'(bus.issue_rdy), 32'(model_credits() != 0));
            compare("credits", 32'(bus.credits), 32'(model_credits()));
        end
        compare("deq_val", 32'(bus.deq_val), 32'(exp_count != 0));
        compare("count", 32'(bus.count), 32'(exp_count));
        compare("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (exp_count != 0 && sb_q.size() != 0)
            compare("deq_data", 32'(bus.deq_data), 32'(sb_q[0]));
    endtask

    // One clock cycle of stimulus. force_pv overrides the delay-line output
    // to emulate an upstream that ignores issue_rdy.
    task automatic apply_stimulus(input bit iv, input bit dr, input bit force_pv,
                                  input logic [DW-1:0] force_data);
        slot_t cur;
        bit    m_rdy, issue_fire, deq_fire, enq;
        @(negedge clk);
        cur = dl[0];
        if (force_pv) begin
            cur.v = 1'b1;
            cur.d = force_data;
        end
        m_rdy         = (model_credits() != 0);
        bus.issue_val = iv;
        bus.deq_rdy   = dr;
        bus.pipe_val  = cur.v;
        bus.pipe_data = cur.v ? cur.d : DW'($urandom);
        #1;
        check_output();
        #2;
        issue_fire = iv && m_rdy;
        deq_fire   = dr && (exp_count != 0);
        enq        = cur.v && ((exp_count < DEPTH) || deq_fire);
        if (cur.v && exp_count == DEPTH && !deq_fire) m_ovf = 1'b1;
        if (enq) sb_q.push_back(cur.d);
        exp_count = exp_count + int'(enq) - int'(deq_fire);
        dl.delete(0);
        if (issue_fire) begin
            dl.push_back(slot_t'{v: 1'b1, d: next_data});
            next_data = next_data + 1'b1;
        end else begin
            dl.push_back('0);
        end
    endtask

    // Asserts reset between clock edges and checks it acts immediately.
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        reset         = 1'b1;
        bus.issue_val = 1'b0;
        bus.deq_rdy   = 1'b0;
        bus.pipe_val  = 1'b0;
        #1;
        reset_model();
        check_output();
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every dequeue the DUT performs must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && bus.deq_val === 1'b1 && bus.deq_rdy === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL deq_unexpected: got %0h expected no dequeue at %0t",
                             bus.deq_data, $time);
                end else begin
                    mon_exp = sb_q.pop_front();
                    compare("deq_order", 32'(bus.deq_data), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        bus.issue_val = 1'b0;
        bus.deq_rdy   = 1'b0;
        bus.pipe_val  = 1'b0;
        bus.pipe_data = '0;
        reset_model();
        #1 reset = 1'b1;
        #1 check_output();
        @(negedge clk);
        #1 reset = 1'b0;

        // Streaming with a consumer that is always ready.
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++)  apply_stimulus(1'b0, 1'b1, 1'b0, '0);

        // Stalled consumer: credits run out, queue fills, then drains.
        for (int i = 0; i < 8; i++)  apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++)  apply_stimulus(1'b0, 1'b1, 1'b0, '0);

        // Head held stable while more results arrive behind it.
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++)  apply_stimulus(1'b0, 1'b1, 1'b0, '0);

        // Alternating consumer readiness across many pointer wraps.
        for (int i = 0; i < 24; i++) apply_stimulus(1'b1, (i % 2) == 0, 1'b0, '0);
        for (int i = 0; i < 6; i++)  apply_stimulus(1'b0, 1'b1, 1'b0, '0);

        // Random traffic.
        for (int i = 0; i < 150; i++)
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
        for (int i = 0; i < 6; i++)  apply_stimulus(1'b0, 1'b1, 1'b0, '0);

        // Full queue: a forced write with a simultaneous dequeue is legal,
        // a forced write without one is dropped and flags overflow.
        for (int i = 0; i < 6; i++)  apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        check_credits = 1'b0;
        apply_stimulus(1'b0, 1'b1, 1'b1, 12'hABC);
        apply_stimulus(1'b0, 1'b0, 1'b1, 12'hDEF);
        for (int i = 0; i < 6; i++)  apply_stimulus(1'b0, 1'b1, 1'b0, '0);
        compare("violation_drain_empty", 32'(sb_q.size()), 32'd0);
        pulse_reset();

        // Reset with two results queued and one in flight.
        for (int i = 0; i < 3; i++)  apply_stimulus(1'b1, 1'b0, 1'b0, '0);
        pulse_reset();
        for (int i = 0; i < 4; i++)  apply_stimulus(1'b0, 1'b1, 1'b0, '0);

        // Traffic after reset.
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++)  apply_stimulus(1'b0, 1'b1, 1'b0, '0);

        compare("final_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
